swu_mmv_packer: RTL and testbench

- Transmit-side companion of the sliding window unit (SWU) input port.
- Accepts the IFM as a single-word stream: one SIMD*PRECISION word per beat, channel-fold words of a pixel in order, pixels row-major.
- Packs MMV_IN consecutive words into one MMV_IN*SIMD*PRECISION beat, which is exactly the SWU s_axis format.
- Tracks frame boundaries. A short final beat is zero-filled, and the last beat of every frame is flagged with tlast.

---
 rtl/swu_pkg.sv | 40 ++++
 rtl/swu_frame_counter.sv | 36 +++
 rtl/swu_mmv_packer.sv | 113 +++++++++++
 tb/tb_swu_mmv_packer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/swu_pkg.sv
// Shared helpers for the sliding window unit: data widths, frame sizing and
// counter widths derived from the SWU parameter set.
// No ports; imported by swu_mmv_packer and swu_frame_counter.
package swu_pkg;

  // Round-up integer division.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Bits in one input word (W).
  function automatic int unsigned calc_w(input int unsigned simd, input int unsigned prec);
    return simd * prec;
  endfunction

  // Bits in one packed output beat (WIDTHA = MMV_IN*W).
  function automatic int unsigned calc_widtha(input int unsigned mmv_in, input int unsigned simd,
                                              input int unsigned prec);
    return mmv_in * calc_w(simd, prec);
  endfunction

  // Input words in one IFM frame.
  function automatic int unsigned calc_nwords(input int unsigned ifm_w, input int unsigned ifm_h,
                                              input int unsigned ifm_ch, input int unsigned simd);
    return ifm_w * ifm_h * (ifm_ch / simd);
  endfunction

  // Packed beats in one IFM frame (last one may be zero-filled).
  function automatic int unsigned calc_nbeats(input int unsigned nwords, input int unsigned mmv_in);
    return ceil_div(nwords, mmv_in);
  endfunction

  // Counter width able to hold 0..n, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/swu_frame_counter.sv
// Wrapping counter 0..MAX with a terminal-count flag.
// Ports: clk, rst_n (synchronous active-low), en_i (advance), clr_i (force the
// next advance to wrap to 0), cnt_o (registered count), tc_c (count == MAX).
module swu_frame_counter
  import swu_pkg::*;
#(
  parameter int unsigned MAX   = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_c
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_c  = (cnt_q == WIDTH'(MAX));
  assign cnt_o = cnt_q;

  // Advance, wrapping at MAX or on an external clear.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (tc_c || clr_i) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/swu_mmv_packer.sv
// Packs MMV_IN consecutive SIMD*PRECISION IFM words into one SWU input beat,
// LSB-first, zero-filling a short final beat and flagging the frame's last
// beat with tlast.
// Ports: aclk, aresetn (synchronous active-low); s_axis_* single-word input
// stream; m_axis_* packed beat stream to the SWU; frame_done pulses one cycle
// after the tlast beat handshakes.
module swu_mmv_packer
  import swu_pkg::*;
#(
  parameter int unsigned SIMD        = 1,
  parameter int unsigned PRECISION   = 8,
  parameter int unsigned IFMChannels = 2,
  parameter int unsigned IFMWidth    = 8,
  parameter int unsigned IFMHeight   = 8,
  parameter int unsigned MMV_IN      = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [SIMD*PRECISION-1:0]           s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [MMV_IN*SIMD*PRECISION-1:0]    m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic                                frame_done
);

  localparam int unsigned W      = calc_w(SIMD, PRECISION);
  localparam int unsigned WIDTHA = calc_widtha(MMV_IN, SIMD, PRECISION);
  localparam int unsigned NWORDS = calc_nwords(IFMWidth, IFMHeight, IFMChannels, SIMD);
  localparam int unsigned WCW    = cnt_width(NWORDS);
  localparam int unsigned SCW    = cnt_width(MMV_IN);

  logic              s_hs, m_hs, beat_done;
  logic              word_tc_c, slot_tc_c;
  logic [WCW-1:0]    word_cnt_unused;
  logic [SCW-1:0]    slot_cnt;

  logic [WIDTHA-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              frame_done_q, frame_done_d;

  // Input is accepted whenever the output register is empty or draining.
  assign s_axis_tready = !valid_q | m_axis_tready;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = valid_q & m_axis_tready;
  assign beat_done     = s_hs & (slot_tc_c | word_tc_c);

  // Position of the current word within the frame; only its wrap matters here.
  swu_frame_counter #(.MAX(NWORDS - 1), .WIDTH(WCW)) u_word_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .en_i  (s_hs),
    .clr_i (1'b0),
    .cnt_o (word_cnt_unused),
    .tc_c  (word_tc_c)
  );

  // Slot within the beat; forced back to 0 at the frame wrap so frames never share a beat.
  swu_frame_counter #(.MAX(MMV_IN - 1), .WIDTH(SCW)) u_slot_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .en_i  (s_hs),
    .clr_i (word_tc_c),
    .cnt_o (slot_cnt),
    .tc_c  (slot_tc_c)
  );

  // Beat assembly and output register update.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    frame_done_d = m_hs & last_q;
    if (m_hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (s_hs) begin
      // First word of a beat clears stale slots so a short beat is zero-filled.
      if (slot_cnt == '0) data_d = '0;
      for (int unsigned i = 0; i < MMV_IN; i++) begin
        if (slot_cnt == SCW'(i)) data_d[i*W +: W] = s_axis_tdata;
      end
      if (beat_done) begin
        valid_d = 1'b1;
        last_d  = word_tc_c;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_swu_mmv_packer.sv
// Bench for swu_mmv_packer: default instance (full frame, backpressure,
// mid-frame reset, random handshakes), a 3x3 instance with a zero-filled
// remainder beat, and an MMV_IN=1 instance for back-to-back throughput.
module tb_swu_mmv_packer;

  localparam int NW0 = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0]  d0_s_data;  logic d0_s_valid, d0_s_ready;
  logic [15:0] d0_m_data;  logic d0_m_valid, d0_m_ready, d0_m_last, d0_fd;
  logic [7:0]  d1_s_data;  logic d1_s_valid, d1_s_ready;
  logic [15:0] d1_m_data;  logic d1_m_valid, d1_m_ready, d1_m_last, d1_fd;
  logic [7:0]  d2_s_data;  logic d2_s_valid, d2_s_ready;
  logic [7:0]  d2_m_data;  logic d2_m_valid, d2_m_ready, d2_m_last, d2_fd;

  swu_mmv_packer u_dut0 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(d0_s_data), .s_axis_tvalid(d0_s_valid), .s_axis_tready(d0_s_ready),
    .m_axis_tdata(d0_m_data), .m_axis_tvalid(d0_m_valid), .m_axis_tready(d0_m_ready),
    .m_axis_tlast(d0_m_last), .frame_done(d0_fd)
  );

  swu_mmv_packer #(.SIMD(1), .PRECISION(8), .IFMChannels(1), .IFMWidth(3),
                   .IFMHeight(3), .MMV_IN(2)) u_dut1 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(d1_s_data), .s_axis_tvalid(d1_s_valid), .s_axis_tready(d1_s_ready),
    .m_axis_tdata(d1_m_data), .m_axis_tvalid(d1_m_valid), .m_axis_tready(d1_m_ready),
    .m_axis_tlast(d1_m_last), .frame_done(d1_fd)
  );

  swu_mmv_packer #(.SIMD(1), .PRECISION(8), .IFMChannels(2), .IFMWidth(2),
                   .IFMHeight(2), .MMV_IN(1)) u_dut2 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(d2_s_data), .s_axis_tvalid(d2_s_valid), .s_axis_tready(d2_s_ready),
    .m_axis_tdata(d2_m_data), .m_axis_tvalid(d2_m_valid), .m_axis_tready(d2_m_ready),
    .m_axis_tlast(d2_m_last), .frame_done(d2_fd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver state
  int  d0_word, d0_left, d1_word, d1_left, d2_word, d2_left;
  logic d0_vrand, d0_rrand, d0_hold;

  // Monitor / scoreboard state
  logic [16:0] d0_exp_q[$];
  logic [15:0] d0_got[$];
  logic [16:0] d1_got[$];
  int   d0_lasts, d0_fd_cnt, d1_fd_cnt, d2_beats, d2_lasts, d2_idx;
  int   m0_slot, m0_w;
  logic [15:0] m0_acc;
  logic [16:0] exp_beat;
  logic d0_fd_exp, d0_acc, d1_acc, d2_acc, d2_prev_hs;
  logic [7:0] d2_prev_word;

  // Sample away from the rising edge; reference packing model feeds the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      d0_exp_q.delete();
      m0_acc = '0; m0_slot = 0; m0_w = 0;
      d0_fd_exp = 1'b0; d0_acc = 1'b0; d1_acc = 1'b0; d2_acc = 1'b0;
      d2_prev_hs = 1'b0; d2_idx = 0;
    end else begin
      chk("d0_frame_done", 32'(d0_fd), 32'(d0_fd_exp));
      d0_fd_exp = 1'b0;
      if (d0_fd) d0_fd_cnt++;
      if (d0_m_valid && d0_m_ready) begin
        if (d0_exp_q.size() == 0) begin
          chk("d0_sb_nonempty", 32'(d0_exp_q.size()), 32'd1);
        end else begin
          exp_beat = d0_exp_q.pop_front();
          chk("d0_data", 32'(d0_m_data), 32'(exp_beat[15:0]));
          chk("d0_last", 32'(d0_m_last), 32'(exp_beat[16]));
          d0_fd_exp = exp_beat[16];
        end
        d0_got.push_back(d0_m_data);
        if (d0_m_last) d0_lasts++;
      end
      d0_acc = d0_s_valid && d0_s_ready;
      if (d0_acc) begin
        if (m0_slot == 0) m0_acc = '0;
        m0_acc[m0_slot*8 +: 8] = d0_s_data;
        if (m0_slot == 1 || m0_w == NW0 - 1) begin
          d0_exp_q.push_back({(m0_w == NW0 - 1), m0_acc});
          m0_slot = 0;
        end else begin
          m0_slot++;
        end
        m0_w = (m0_w == NW0 - 1) ? 0 : m0_w + 1;
      end

      d1_acc = d1_s_valid && d1_s_ready;
      if (d1_m_valid && d1_m_ready) d1_got.push_back({d1_m_last, d1_m_data});
      if (d1_fd) d1_fd_cnt++;

      if (d2_prev_hs) begin
        chk("d2_valid", 32'(d2_m_valid), 32'd1);
        chk("d2_data",  32'(d2_m_data),  32'(d2_prev_word));
        chk("d2_last",  32'(d2_m_last),  32'(d2_idx % 8 == 7));
        d2_idx++;
      end
      if (d2_m_valid && d2_m_ready) begin
        d2_beats++;
        if (d2_m_last) d2_lasts++;
      end
      d2_acc       = d2_s_valid && d2_s_ready;
      d2_prev_hs   = d2_acc;
      d2_prev_word = d2_s_data;
    end
  end

  // One clock of stimulus: advance accepted words, then drive the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (d0_acc) begin d0_word++; d0_left--; end
    if (d1_acc) begin d1_word++; d1_left--; end
    if (d2_acc) begin d2_word++; d2_left--; end
    d0_s_data = 8'(d0_word);
    if (!(d0_s_valid && !d0_acc))
      d0_s_valid = (d0_left > 0) && (!d0_vrand || $urandom_range(0, 1) == 1);
    d0_m_ready = d0_hold ? 1'b0 : (!d0_rrand || $urandom_range(0, 1) == 1);
    d1_s_data  = 8'(d1_word);
    d1_s_valid = d1_left > 0;
    d2_s_data  = 8'(d2_word);
    d2_s_valid = d2_left > 0;
  endtask

  task automatic run_d0(input int target, input int budget);
    for (int i = 0; i < budget && d0_got.size() < target; i++) tick();
    repeat (3) tick();
  endtask

  task automatic clr_d0();
    d0_got.delete();
    d0_lasts = 0;
    d0_fd_cnt = 0;
  endtask

  logic [15:0] held;
  logic seen;

  initial begin
    rst_n = 1'b0;
    d0_s_data = '0; d0_s_valid = 1'b0; d0_m_ready = 1'b1;
    d1_s_data = '0; d1_s_valid = 1'b0; d1_m_ready = 1'b1;
    d2_s_data = '0; d2_s_valid = 1'b0; d2_m_ready = 1'b1;
    d0_word = 0; d0_left = 0; d1_word = 0; d1_left = 0; d2_word = 0; d2_left = 0;
    d0_vrand = 1'b0; d0_rrand = 1'b0; d0_hold = 1'b0;
    d0_lasts = 0; d0_fd_cnt = 0; d1_fd_cnt = 0; d2_beats = 0; d2_lasts = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(d0_m_valid), 32'd0);
    chk("rst_m_data",  32'(d0_m_data),  32'd0);
    chk("rst_m_last",  32'(d0_m_last),  32'd0);
    chk("rst_fd",      32'(d0_fd),      32'd0);
    chk("rst_s_ready", 32'(d0_s_ready), 32'd1);
    chk("rst_d2_valid", 32'(d2_m_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full default frame, both sides always ready
    clr_d0();
    d0_word = 0; d0_left = NW0;
    run_d0(64, 400);
    chk("full_beats", 32'(d0_got.size()), 32'd64);
    for (int k = 0; k < 64; k++)
      chk("full_beat_k", 32'(d0_got[k]), 32'({8'(2*k+1), 8'(2*k)}));
    chk("full_lasts", 32'(d0_lasts), 32'd1);
    chk("full_fd",    32'(d0_fd_cnt), 32'd1);

    // Backpressure after the first beat completes
    clr_d0();
    d0_hold = 1'b1; d0_word = 0; d0_left = NW0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      @(negedge clk);
      seen = d0_m_valid;
    end
    held = d0_m_data;
    chk("bp_first", 32'(held), 32'h0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("bp_valid",   32'(d0_m_valid), 32'd1);
      chk("bp_data",    32'(d0_m_data),  32'(held));
      chk("bp_s_ready", 32'(d0_s_ready), 32'd0);
    end
    d0_hold = 1'b0;
    run_d0(64, 400);
    chk("bp_beats", 32'(d0_got.size()), 32'd64);
    chk("bp_tail",  32'(d0_got[63]), 32'h7f7e);
    chk("bp_lasts", 32'(d0_lasts), 32'd1);

    // Reset after 5 words of a frame
    clr_d0();
    d0_word = 0; d0_left = NW0;
    for (int i = 0; i < 20 && d0_word < 5; i++) tick();
    rst_n = 1'b0;
    d0_s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0_word = 0; d0_left = NW0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(d0_m_valid), 32'd0);
    clr_d0();
    run_d0(64, 400);
    chk("mid_rst_beats", 32'(d0_got.size()), 32'd64);
    chk("mid_rst_first", 32'(d0_got[0]), 32'h0100);
    chk("mid_rst_lasts", 32'(d0_lasts), 32'd1);

    // Random valid/ready across three frames
    clr_d0();
    d0_vrand = 1'b1; d0_rrand = 1'b1; d0_word = 0; d0_left = 3 * NW0;
    run_d0(192, 5000);
    d0_vrand = 1'b0; d0_rrand = 1'b0;
    repeat (3) tick();
    chk("rnd_beats", 32'(d0_got.size()), 32'd192);
    chk("rnd_lasts", 32'(d0_lasts), 32'd3);
    chk("rnd_fd",    32'(d0_fd_cnt), 32'd3);
    chk("rnd_sb_left", 32'(d0_exp_q.size()), 32'd0);

    // 3x3 frame of 9 words, then the start of a second frame
    d1_word = 1; d1_left = 13;
    for (int i = 0; i < 60 && d1_got.size() < 7; i++) tick();
    repeat (3) tick();
    chk("rem_beats", 32'(d1_got.size()), 32'd7);
    chk("rem_beat0", 32'(d1_got[0]), 32'h00201);
    chk("rem_beat3", 32'(d1_got[3]), 32'h00807);
    chk("rem_beat4", 32'(d1_got[4]), 32'h10009);
    chk("rem_beat5", 32'(d1_got[5]), 32'h00b0a);
    chk("rem_beat6", 32'(d1_got[6]), 32'h00d0c);
    chk("rem_fd",    32'(d1_fd_cnt), 32'd1);

    // MMV_IN=1: one beat per cycle, two 8-word frames
    d2_word = 32'h20; d2_left = 16;
    for (int i = 0; i < 60 && d2_beats < 16; i++) tick();
    repeat (3) tick();
    chk("mmv1_beats", 32'(d2_beats), 32'd16);
    chk("mmv1_lasts", 32'(d2_lasts), 32'd2);
    chk("mmv1_idx",   32'(d2_idx),   32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
